// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet output checker: FSM state encoding, LED
// status codes and the saturating mismatch-count adder.
package lenet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } chk_state_e;

  localparam logic [7:0] LED_PASS = 8'hAA;
  localparam logic [7:0] LED_OFF  = 8'h00;

  // Up to two mismatch events can land in one cycle (late compare plus overflow).
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/output_checker_mismatch_capture.sv
// First-error latch and saturating mismatch counter for output_checker.
// Compare mismatches take priority over overflow, which takes priority over timeout.
module mismatch_capture
  import lenet_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     cmp_mis_i,
  input  logic [IDX_W-1:0]         cmp_idx_i,
  input  logic signed [DATA_W-1:0] cmp_act_i,
  input  logic signed [DATA_W-1:0] cmp_exp_i,
  input  logic                     ovf_i,
  input  logic [IDX_W-1:0]         ovf_idx_i,
  input  logic signed [DATA_W-1:0] ovf_act_i,
  input  logic                     tmo_i,
  input  logic [IDX_W-1:0]         tmo_idx_i,
  output logic [15:0]              count_o,
  output logic [IDX_W-1:0]         err_index_o,
  output logic signed [DATA_W-1:0] err_actual_o,
  output logic signed [DATA_W-1:0] err_expected_o
);

  logic [15:0]              count_q, count_d;
  logic                     have_q, have_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] act_q, act_d;
  logic signed [DATA_W-1:0] exp_q, exp_d;
  logic [1:0]               inc;

  always_comb begin
    inc     = {1'b0, cmp_mis_i} + {1'b0, ovf_i};
    count_d = sat_add16(count_q, inc);
    have_d  = have_q;
    idx_d   = idx_q;
    act_d   = act_q;
    exp_d   = exp_q;
    if (!have_q) begin
      if (cmp_mis_i) begin
        have_d = 1'b1;
        idx_d  = cmp_idx_i;
        act_d  = cmp_act_i;
        exp_d  = cmp_exp_i;
      end else if (ovf_i) begin
        have_d = 1'b1;
        idx_d  = ovf_idx_i;
        act_d  = ovf_act_i;
        exp_d  = '0;
      end else if (tmo_i) begin
        have_d = 1'b1;
        idx_d  = tmo_idx_i;
        act_d  = '0;
        exp_d  = '0;
      end
    end
    if (clr_i) begin
      count_d = '0;
      have_d  = 1'b0;
      idx_d   = '0;
      act_d   = '0;
      exp_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      have_q  <= 1'b0;
      idx_q   <= '0;
      act_q   <= '0;
      exp_q   <= '0;
    end else begin
      count_q <= count_d;
      have_q  <= have_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      exp_q   <= exp_d;
    end
  end

  assign count_o        = count_q;
  assign err_index_o    = idx_q;
  assign err_actual_o   = act_q;
  assign err_expected_o = exp_q;

endmodule

// File: rtl/output_checker.sv
// Compares streamed layer output beats against a synchronous golden ROM.
// Optional idle-timeout watchdog enabled by defining CHECKER_TIMEOUT_EN.
module output_checker
  import lenet_pkg::*;
#(
  parameter int OUTPUT_COUNT   = 196,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     data_valid_in,
  input  logic signed [DATA_W-1:0] pixel_in,
  input  logic                     layer_done,
  output logic [IDX_W-1:0]         golden_addr,
  input  logic signed [DATA_W-1:0] golden_data,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [15:0]              mismatch_count,
  output logic [IDX_W-1:0]         err_index,
  output logic signed [DATA_W-1:0] err_actual,
  output logic signed [DATA_W-1:0] err_expected,
  output logic [7:0]               led
);

  if (OUTPUT_COUNT < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("output_checker: OUTPUT_COUNT must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_COUNT - 1);
  localparam logic [IDX_W-1:0] OVF_IDX  = IDX_W'(OUTPUT_COUNT);

  chk_state_e               state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic                     force_fail_q, force_fail_d;
  logic                     cmp_vld_q;
  logic signed [DATA_W-1:0] cmp_pix_q;
  logic [IDX_W-1:0]         cmp_idx_q;
  logic                     accept, arm, ovf, cmp_mis, tmo;

  assign accept  = (state_q == ST_CHECK) && data_valid_in;
  assign arm     = start && (state_q == ST_IDLE || state_q == ST_PASS || state_q == ST_FAIL);
  assign ovf     = data_valid_in && !arm &&
                   (state_q == ST_DRAIN || state_q == ST_PASS || state_q == ST_FAIL);
  assign cmp_mis = cmp_vld_q && (cmp_pix_q != golden_data);

`ifdef CHECKER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] idle_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_CHECK || accept) idle_q <= '0;
    else                                      idle_q <= idle_q + TMO_W'(1);
  end

  assign tmo = (state_q == ST_CHECK) && !accept && (idle_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    force_fail_d = force_fail_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_CHECK;
          ptr_d        = '0;
          force_fail_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          ptr_d = ptr_q + IDX_W'(1);
          if (ptr_q == LAST_IDX) state_d = ST_DRAIN;
        end
        // Underflow: the in-flight compare still resolves while in DRAIN.
        if (layer_done) begin
          state_d      = ST_DRAIN;
          force_fail_d = 1'b1;
        end else if (tmo) begin
          state_d = ST_FAIL;
        end
      end
      ST_DRAIN: begin
        if (ovf || force_fail_q || mismatch_count != 16'd0 || cmp_mis) state_d = ST_FAIL;
        else                                                          state_d = ST_PASS;
      end
      ST_PASS, ST_FAIL: begin
        if (arm) begin
          state_d      = ST_CHECK;
          ptr_d        = '0;
          force_fail_d = 1'b0;
        end else if (ovf) begin
          state_d = ST_FAIL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      force_fail_q <= 1'b0;
      cmp_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      force_fail_q <= force_fail_d;
      cmp_vld_q    <= accept;
    end
  end

  // Accepted beat is held one cycle to meet the ROM's registered read data.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmp_pix_q <= pixel_in;
      cmp_idx_q <= ptr_q;
    end
  end

  mismatch_capture #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_capture (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (arm),
    .cmp_mis_i      (cmp_mis),
    .cmp_idx_i      (cmp_idx_q),
    .cmp_act_i      (cmp_pix_q),
    .cmp_exp_i      (golden_data),
    .ovf_i          (ovf),
    .ovf_idx_i      (OVF_IDX),
    .ovf_act_i      (pixel_in),
    .tmo_i          (tmo),
    .tmo_idx_i      (ptr_q),
    .count_o        (mismatch_count),
    .err_index_o    (err_index),
    .err_actual_o   (err_actual),
    .err_expected_o (err_expected)
  );

  assign golden_addr = (state_q == ST_CHECK) ? ptr_q : '0;
  assign busy        = (state_q == ST_CHECK) || (state_q == ST_DRAIN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);

  always_comb begin
    led = LED_OFF;
    if (state_q == ST_PASS)      led = LED_PASS;
    else if (state_q == ST_FAIL) led = {1'b1, err_actual[6:0]};
  end

endmodule

// File: tb/tb_output_checker.sv
// Directed bench for output_checker with a behavioural synchronous golden ROM.
module tb_output_checker;

  localparam int N = 196;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              data_valid_in = 1'b0;
  logic signed [7:0] pixel_in = '0;
  logic              layer_done = 1'b0;
  logic [7:0]        golden_addr;
  logic signed [7:0] golden_data;
  logic              busy, pass, fail;
  logic [15:0]       mismatch_count;
  logic [7:0]        err_index;
  logic signed [7:0] err_actual, err_expected;
  logic [7:0]        led;

  logic [7:0] gold [0:N-1];
  int n_checks = 0;
  int n_fail   = 0;

  output_checker #(
    .OUTPUT_COUNT   (N),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .data_valid_in  (data_valid_in),
    .pixel_in       (pixel_in),
    .layer_done     (layer_done),
    .golden_addr    (golden_addr),
    .golden_data    (golden_data),
    .busy           (busy),
    .pass           (pass),
    .fail           (fail),
    .mismatch_count (mismatch_count),
    .err_index      (err_index),
    .err_actual     (err_actual),
    .err_expected   (err_expected),
    .led            (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) golden_data <= gold[golden_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] val, input int gap);
    data_valid_in = 1'b1;
    pixel_in      = val;
    tick();
    data_valid_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    data_valid_in = 1'b0;
    layer_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_fail"}, 32'(fail), 0);
    check({tag, "_cnt"},  32'(mismatch_count), 0);
    check({tag, "_eidx"}, 32'(err_index), 0);
    check({tag, "_eact"}, {24'h0, err_actual}, 0);
    check({tag, "_eexp"}, {24'h0, err_expected}, 0);
    check({tag, "_led"},  32'(led), 0);
    check({tag, "_addr"}, 32'(golden_addr), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) gold[i] = 8'((i * 13 + 7) & 8'hFF);
    gold[37] = 8'd3;

    // Reset state
    do_reset();
    check_all_zero("rst");

    // Beats in IDLE are ignored
    send_beat(8'h11, 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_fail", 32'(fail), 0);
    check("idle_cnt", 32'(mismatch_count), 0);

    // Clean back-to-back run
    pulse_start();
    check("arm_busy", 32'(busy), 1);
    check("arm_addr", 32'(golden_addr), 0);
    send_beat(gold[0], 0);
    check("addr_follow", 32'(golden_addr), 1);
    for (int i = 1; i < N; i++) send_beat(gold[i], 0);
    check("drain_busy", 32'(busy), 1);
    check("drain_pass", 32'(pass), 0);
    tick();
    check("ok_pass", 32'(pass), 1);
    check("ok_fail", 32'(fail), 0);
    check("ok_busy", 32'(busy), 0);
    check("ok_led", 32'(led), 32'hAA);
    check("ok_cnt", 32'(mismatch_count), 0);

    // Single mismatch at beat 37, re-armed from PASS
    pulse_start();
    for (int i = 0; i < N; i++) send_beat((i == 37) ? 8'd5 : gold[i], 0);
    tick();
    check("m37_fail", 32'(fail), 1);
    check("m37_pass", 32'(pass), 0);
    check("m37_eidx", 32'(err_index), 37);
    check("m37_eact", {24'h0, err_actual}, 5);
    check("m37_eexp", {24'h0, err_expected}, 3);
    check("m37_led", 32'(led), 32'h85);
    check("m37_cnt", 32'(mismatch_count), 1);

    // Two mismatches with gaps, and a start pulse mid-run that must be ignored
    pulse_start();
    for (int i = 0; i < N; i++) begin
      send_beat((i == 10 || i == 20) ? (gold[i] ^ 8'h01) : gold[i], i % 4);
      if (i == 15) pulse_start();
    end
    tick();
    check("m2_fail", 32'(fail), 1);
    check("m2_eidx", 32'(err_index), 10);
    check("m2_eact", {24'h0, err_actual}, 32'(gold[10] ^ 8'h01));
    check("m2_eexp", {24'h0, err_expected}, 32'(gold[10]));
    check("m2_cnt", 32'(mismatch_count), 2);

    // Overflow: extra beat after a passing run
    pulse_start();
    for (int i = 0; i < N; i++) send_beat(gold[i], 0);
    tick();
    check("ovf_pass_first", 32'(pass), 1);
    send_beat(8'h42, 0);
    check("ovf_fail", 32'(fail), 1);
    check("ovf_eidx", 32'(err_index), 196);
    check("ovf_cnt", 32'(mismatch_count), 1);
    check("ovf_eact", {24'h0, err_actual}, 32'h42);
    check("ovf_led", 32'(led), 32'hC2);

    // Underflow: layer_done after 100 beats
    pulse_start();
    for (int i = 0; i < 100; i++) send_beat(gold[i], 0);
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    tick();
    check("udf_fail", 32'(fail), 1);
    check("udf_busy", 32'(busy), 0);
    check("udf_cnt", 32'(mismatch_count), 0);

    // Reset mid-CHECK with a mismatch already recorded
    pulse_start();
    for (int i = 0; i < 50; i++) send_beat((i == 5) ? 8'h80 : gold[i], 0);
    check("pre_rst_cnt", 32'(mismatch_count), 1);
    do_reset();
    check_all_zero("midrst");
    pulse_start();
    for (int i = 0; i < N; i++) send_beat(gold[i], 0);
    tick();
    check("fresh_pass", 32'(pass), 1);
    check("fresh_cnt", 32'(mismatch_count), 0);

    // Stall after 60 beats
    pulse_start();
    for (int i = 0; i < 60; i++) send_beat(gold[i], 0);
`ifdef CHECKER_TIMEOUT_EN
    repeat (49) tick();
    check("tmo_early_busy", 32'(busy), 1);
    check("tmo_early_fail", 32'(fail), 0);
    tick();
    check("tmo_fail", 32'(fail), 1);
    check("tmo_eidx", 32'(err_index), 60);
    check("tmo_cnt", 32'(mismatch_count), 0);
`else
    repeat (200) tick();
    check("stall_busy", 32'(busy), 1);
    check("stall_fail", 32'(fail), 0);
    check("stall_cnt", 32'(mismatch_count), 0);
`endif
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
